// File: rtl/control_sequencer.sv
// Hardwired control unit: one instruction cycle (fetch, decode, ALU or MUL/DIV execute) per start.
// Optional divide support is enabled by defining CTRL_SEQ_DIV_EN.
module control_sequencer (
   input  logic        clock,
   input  logic        clear,
   input  logic        start,
   input  logic        mem_ready,
   input  logic [31:0] IR,
   output logic [15:0] Rin,
   output logic [15:0] Rout,
   output logic        PCout,
   output logic        MARin,
   output logic        IncPC,
   output logic        Zin,
   output logic        Zlowout,
   output logic        Zhighout,
   output logic        PCin,
   output logic        Read,
   output logic        MDRin,
   output logic        MDRout,
   output logic        IRin,
   output logic        Yin,
   output logic        LOin,
   output logic        HIin,
   output logic        ADD,
   output logic        SUB,
   output logic        AND,
   output logic        OR,
   output logic        MUL,
   output logic        DIV,
   output logic        busy,
   output logic        done,
   output logic        illegal
);

   localparam int unsigned NREG  = 16;
   localparam int unsigned OP_W  = 5;
   localparam int unsigned REG_W = 4;

`ifdef CTRL_SEQ_DIV_EN
   localparam bit DIV_EN = 1'b1;
`else
   localparam bit DIV_EN = 1'b0;
`endif

   localparam logic [OP_W-1:0] OP_ADD = 5'b00011;
   localparam logic [OP_W-1:0] OP_SUB = 5'b00100;
   localparam logic [OP_W-1:0] OP_AND = 5'b00101;
   localparam logic [OP_W-1:0] OP_OR  = 5'b00110;
   localparam logic [OP_W-1:0] OP_MUL = 5'b01111;
   localparam logic [OP_W-1:0] OP_DIV = 5'b10000;

   typedef enum logic [3:0] {IDLE, T0, T1, T2, T3, T4, T5, T6, DONE} state_t;

   typedef struct packed {
      logic [OP_W-1:0]  op;
      logic [REG_W-1:0] ra;
      logic [REG_W-1:0] rb;
      logic [REG_W-1:0] rc;
   } fields_t;

   typedef struct packed {
      logic [NREG-1:0] rin;
      logic [NREG-1:0] rout;
      logic pcout, marin, incpc, zin, zlowout, zhighout, pcin, read;
      logic mdrin, mdrout, irin, yin, loin, hiin;
      logic add, sub, and_op, or_op, mul, div;
      logic busy, done;
   } strobe_t;

   function automatic logic is_alu(input logic [OP_W-1:0] op);
      return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) || (op == OP_OR);
   endfunction

   function automatic logic is_muldiv(input logic [OP_W-1:0] op);
      return (op == OP_MUL) || (DIV_EN && (op == OP_DIV));
   endfunction

   state_t  state_q, state_d;
   fields_t fld_q, fld_d;
   strobe_t str_q, str_d;
   logic    illegal_q, illegal_d;

   // Only op/ra/rb/rc are consumed; the immediate/low bits are don't-care here.
   logic unused_ir_bits;
   assign unused_ir_bits = ^IR[14:0];

   // State, latched fields, flag and strobe registers
   always_ff @(posedge clock) begin
      if (!clear) begin
         state_q   <= IDLE;
         fld_q     <= '0;
         str_q     <= '0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         fld_q     <= fld_d;
         str_q     <= str_d;
         illegal_q <= illegal_d;
      end
   end

   // Next state, then strobes decoded from the next state so the registered outputs align with it
   always_comb begin
      state_d   = state_q;
      fld_d     = fld_q;
      illegal_d = illegal_q;
      str_d     = '0;

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d   = T0;
               illegal_d = 1'b0;
            end
         end
         T0: state_d = T1;
         T1: if (mem_ready) state_d = T2;
         T2: begin
            fld_d = fields_t'({IR[31:27], IR[26:23], IR[22:19], IR[18:15]});
            if (is_alu(IR[31:27]) || is_muldiv(IR[31:27])) begin
               state_d = T3;
            end else begin
               state_d   = DONE;
               illegal_d = 1'b1;
            end
         end
         T3: state_d = T4;
         T4: state_d = T5;
         T5: state_d = is_muldiv(fld_q.op) ? T6 : DONE;
         T6: state_d = DONE;
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase

      str_d.busy = (state_d != IDLE);
      case (state_d)
         T0: begin
            str_d.pcout = 1'b1;
            str_d.marin = 1'b1;
            str_d.incpc = 1'b1;
            str_d.zin   = 1'b1;
         end
         T1: begin
            str_d.read    = 1'b1;
            str_d.mdrin   = 1'b1;
            str_d.zlowout = (state_q == T0);
            str_d.pcin    = (state_q == T0);
         end
         T2: begin
            str_d.mdrout = 1'b1;
            str_d.irin   = 1'b1;
         end
         T3: begin
            str_d.yin  = 1'b1;
            str_d.rout = is_muldiv(fld_d.op) ? NREG'(1) << fld_d.ra : NREG'(1) << fld_d.rb;
         end
         T4: begin
            str_d.zin    = 1'b1;
            str_d.rout   = is_muldiv(fld_d.op) ? NREG'(1) << fld_d.rb : NREG'(1) << fld_d.rc;
            str_d.add    = (fld_d.op == OP_ADD);
            str_d.sub    = (fld_d.op == OP_SUB);
            str_d.and_op = (fld_d.op == OP_AND);
            str_d.or_op  = (fld_d.op == OP_OR);
            str_d.mul    = (fld_d.op == OP_MUL);
            str_d.div    = DIV_EN && (fld_d.op == OP_DIV);
         end
         T5: begin
            str_d.zlowout = 1'b1;
            if (is_muldiv(fld_d.op)) str_d.loin = 1'b1;
            else                     str_d.rin  = NREG'(1) << fld_d.ra;
         end
         T6: begin
            str_d.zhighout = 1'b1;
            str_d.hiin     = 1'b1;
         end
         DONE: str_d.done = 1'b1;
         default: ;
      endcase
   end

   assign Rin      = str_q.rin;
   assign Rout     = str_q.rout;
   assign PCout    = str_q.pcout;
   assign MARin    = str_q.marin;
   assign IncPC    = str_q.incpc;
   assign Zin      = str_q.zin;
   assign Zlowout  = str_q.zlowout;
   assign Zhighout = str_q.zhighout;
   assign PCin     = str_q.pcin;
   assign Read     = str_q.read;
   assign MDRin    = str_q.mdrin;
   assign MDRout   = str_q.mdrout;
   assign IRin     = str_q.irin;
   assign Yin      = str_q.yin;
   assign LOin     = str_q.loin;
   assign HIin     = str_q.hiin;
   assign ADD      = str_q.add;
   assign SUB      = str_q.sub;
   assign AND      = str_q.and_op;
   assign OR       = str_q.or_op;
   assign MUL      = str_q.mul;
   assign DIV      = str_q.div;
   assign busy     = str_q.busy;
   assign done     = str_q.done;
   assign illegal  = illegal_q;

endmodule

// File: tb/tb_control_sequencer.sv
// Randomized bench for control_sequencer: expected per-cycle strobe lists are built from the instruction rules.
module tb_control_sequencer;

   logic        clock = 1'b0;
   logic        clear, start, mem_ready;
   logic [31:0] IR;
   logic [15:0] Rin, Rout;
   logic PCout, MARin, IncPC, Zin, Zlowout, Zhighout, PCin, Read, MDRin, MDRout, IRin;
   logic Yin, LOin, HIin, ADD, SUB, AND, OR, MUL, DIV, busy, done, illegal;

   control_sequencer dut (
      .clock(clock), .clear(clear), .start(start), .mem_ready(mem_ready), .IR(IR),
      .Rin(Rin), .Rout(Rout), .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .Zin(Zin),
      .Zlowout(Zlowout), .Zhighout(Zhighout), .PCin(PCin), .Read(Read), .MDRin(MDRin),
      .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .LOin(LOin), .HIin(HIin), .ADD(ADD),
      .SUB(SUB), .AND(AND), .OR(OR), .MUL(MUL), .DIV(DIV), .busy(busy), .done(done),
      .illegal(illegal)
   );

   always #5 clock = ~clock;

`ifdef CTRL_SEQ_DIV_EN
   localparam bit DIV_EN = 1'b1;
`else
   localparam bit DIV_EN = 1'b0;
`endif

   typedef struct packed {
      logic [15:0] rin;
      logic [15:0] rout;
      logic pcout, marin, incpc, zin, zlowout, zhighout, pcin, read;
      logic mdrin, mdrout, irin, yin, loin, hiin;
      logic add, sub, and_, or_, mul, div;
      logic busy, done, illegal;
   } obs_t;

   int   vectors = 0;
   int   miscompares = 0;
   obs_t exp_q[$];
   logic model_illegal = 1'b0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
      vectors++;
      if (got !== want) begin
         miscompares++;
         $display("FAIL %s: observed %h expected %h", tag, got, want);
      end
   endtask

   function automatic obs_t sample();
      obs_t s;
      s = '{rin: Rin, rout: Rout, pcout: PCout, marin: MARin, incpc: IncPC, zin: Zin,
            zlowout: Zlowout, zhighout: Zhighout, pcin: PCin, read: Read, mdrin: MDRin,
            mdrout: MDRout, irin: IRin, yin: Yin, loin: LOin, hiin: HIin, add: ADD,
            sub: SUB, and_: AND, or_: OR, mul: MUL, div: DIV, busy: busy, done: done,
            illegal: illegal};
      return s;
   endfunction

   function automatic obs_t idle_vec();
      obs_t v = '0;
      v.illegal = model_illegal;
      return v;
   endfunction

   // Expected cycle-by-cycle strobes from T0 to DONE for one instruction with w memory wait cycles
   task automatic build(input logic [31:0] ir, input int w);
      obs_t v;
      logic [4:0] op = ir[31:27];
      logic [3:0] ra = ir[26:23];
      logic [3:0] rb = ir[22:19];
      logic [3:0] rc = ir[18:15];
      int kind; // 0 alu, 1 mul/div, 2 illegal
      exp_q.delete();
      case (op)
         5'd3, 5'd4, 5'd5, 5'd6: kind = 0;
         5'd15:                  kind = 1;
         5'd16:                  kind = DIV_EN ? 1 : 2;
         default:                kind = 2;
      endcase
      v = '0; v.busy = 1; v.pcout = 1; v.marin = 1; v.incpc = 1; v.zin = 1; exp_q.push_back(v);
      v = '0; v.busy = 1; v.read = 1; v.mdrin = 1; v.zlowout = 1; v.pcin = 1; exp_q.push_back(v);
      for (int k = 0; k < w; k++) begin
         v = '0; v.busy = 1; v.read = 1; v.mdrin = 1; exp_q.push_back(v);
      end
      v = '0; v.busy = 1; v.mdrout = 1; v.irin = 1; exp_q.push_back(v);
      if (kind == 0) begin
         v = '0; v.busy = 1; v.yin = 1; v.rout = 16'(1) << rb; exp_q.push_back(v);
         v = '0; v.busy = 1; v.zin = 1; v.rout = 16'(1) << rc;
         v.add = (op == 5'd3); v.sub = (op == 5'd4); v.and_ = (op == 5'd5); v.or_ = (op == 5'd6);
         exp_q.push_back(v);
         v = '0; v.busy = 1; v.zlowout = 1; v.rin = 16'(1) << ra; exp_q.push_back(v);
      end else if (kind == 1) begin
         v = '0; v.busy = 1; v.yin = 1; v.rout = 16'(1) << ra; exp_q.push_back(v);
         v = '0; v.busy = 1; v.zin = 1; v.rout = 16'(1) << rb;
         v.mul = (op == 5'd15); v.div = (op == 5'd16); exp_q.push_back(v);
         v = '0; v.busy = 1; v.zlowout = 1; v.loin = 1; exp_q.push_back(v);
         v = '0; v.busy = 1; v.zhighout = 1; v.hiin = 1; exp_q.push_back(v);
      end
      v = '0; v.busy = 1; v.done = 1; v.illegal = (kind == 2); exp_q.push_back(v);
   endtask

   // Issue one instruction; abort_at >= 0 pulls clear low during that cycle index
   task automatic run(input string name, input logic [31:0] ir, input int w, input int abort_at);
      int   n;
      bit   aborted = 0;
      build(ir, w);
      n = exp_q.size();
      IR = ir; start = 1'b1; clear = 1'b1; mem_ready = 1'($urandom);
      @(posedge clock); #1;
      for (int i = 0; i < n; i++) begin
         check($sformatf("%s c%0d", name, i), 64'(sample()), 64'(exp_q[i]));
         start = 1'($urandom);
         if (i >= 1 && i <= 1 + w) mem_ready = (i == 1 + w);
         else                      mem_ready = 1'($urandom);
         if (i >= 3 + w) IR = $urandom;
         clear = (i == abort_at) ? 1'b0 : 1'b1;
         if (i == abort_at) start = 1'b1;
         @(posedge clock); #1;
         if (i == abort_at) begin
            model_illegal = 1'b0;
            check($sformatf("%s abort", name), 64'(sample()), 64'(0));
            aborted = 1;
            break;
         end
      end
      if (!aborted) model_illegal = exp_q[n-1].illegal;
      clear = 1'b1; start = 1'b0;
      check($sformatf("%s idle0", name), 64'(sample()), 64'(idle_vec()));
      @(posedge clock); #1;
      check($sformatf("%s idle1", name), 64'(sample()), 64'(idle_vec()));
   endtask

   logic [4:0] legal_ops [6] = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd15, 5'd16};

   initial begin
      logic [31:0] ir;
      logic [4:0]  op;
      int          w, ab;
      clear = 1'b0; start = 1'b1; mem_ready = 1'b1; IR = 32'h7988_0000;
      repeat (2) @(posedge clock);
      #1 check("reset", 64'(sample()), 64'(0));
      clear = 1'b1; start = 1'b0;
      @(posedge clock); #1 check("idle after reset", 64'(sample()), 64'(0));

      run("mul r3 r1",  32'h7988_0000, 0, -1);
      run("add r2",     32'h192B_0000, 0, -1);
      run("add wait3",  32'h192B_0000, 3, -1);
      run("illegal",    32'hF800_0000, 0, -1);
      run("after ill",  32'h192B_0000, 1, -1);
      run("mul abortT4", 32'h7988_0000, 0, 4);
      run("mul rerun",  32'h7988_0000, 0, -1);
      run("abort wait", 32'h7988_0000, 3, 3);
      run("div r0",     32'h8000_0000, 1, -1);
      run("div after",  32'h8000_0000, 0, -1);

      // clear wins over start while idle
      start = 1'b1; clear = 1'b0;
      @(posedge clock); #1 check("clear over start", 64'(sample()), 64'(0));
      clear = 1'b1; start = 1'b0;
      @(posedge clock); #1 check("still idle", 64'(sample()), 64'(0));

      for (int k = 0; k < 60; k++) begin
         if ($urandom_range(0, 4) == 0) op = 5'($urandom);
         else                           op = legal_ops[$urandom_range(0, 5)];
         ir = {op, 27'($urandom)};
         w  = int'($urandom_range(0, 3));
         ab = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 5)) : -1;
         run($sformatf("rnd%0d op%0d", k, op), ir, w, ab);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
